// File: rtl/instr_fetch_sequencer_if.sv
// rtl/instr_fetch_sequencer_if.sv - instruction memory fetch bus between sequencer and imem
interface instr_fetch_sequencer_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/instr_fetch_sequencer.sv
// rtl/instr_fetch_sequencer.sv - fetch/issue sequencer with next-PC selection and fetch timeout
module instr_fetch_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instr_fetch_sequencer_if.master  imem,
    output logic [2:0]               opcode,
    output logic [15:0]              instr,
    output logic                     instr_valid,
    output logic [PC_W-1:0]          pc,
    input  logic                     j_in,
    input  logic                     beq_in,
    input  logic                     jmpg_in,
    input  logic                     alu_zero,
    input  logic                     alu_gt,
    input  logic                     ex_done,
    output logic                     fetch_err
);

    localparam int              TMO_W       = $clog2(TIMEOUT) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT - 1);
    // Low 13 bits are the J-type target field; the bits above stay in the current region.
    localparam logic [PC_W-1:0] REGION_MASK = PC_W'(13'h1FFF);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_ISSUE = 2'd2
    } seqState_t;

    seqState_t        state;
    seqState_t        stateNext;
    logic [PC_W-1:0]  pcReg;
    logic [15:0]      ir;
    logic [TMO_W-1:0] tmoCnt;
    logic             fetchErr;

    logic             loadIr;
    logic             advancePc;
    logic             tmoInc;
    logic             tmoClr;
    logic             setErr;

    logic [PC_W-1:0]  pc1;
    logic [PC_W-1:0]  brTgt;
    logic [PC_W-1:0]  jTgt;
    logic [PC_W-1:0]  nextPc;

    assign pc1   = pcReg + PC_W'(1);
    assign brTgt = pc1 + {{(PC_W-7){ir[6]}}, ir[6:0]};
    assign jTgt  = (pc1 & ~REGION_MASK) | PC_W'(ir[12:0]);

    // Next-PC priority: J, then taken JmpG, then taken Beq, else sequential.
    always_comb begin
        nextPc = pc1;
        if (j_in) begin
            nextPc = jTgt;
        end else if (jmpg_in && alu_gt) begin
            nextPc = brTgt;
        end else if (beq_in && alu_zero) begin
            nextPc = brTgt;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and datapath control strobes.
    always_comb begin
        stateNext = state;
        loadIr    = 1'b0;
        advancePc = 1'b0;
        tmoInc    = 1'b0;
        tmoClr    = 1'b0;
        setErr    = 1'b0;
        case (state)
            S_IDLE: begin
                stateNext = S_REQ;
            end
            S_REQ: begin
                if (imem.imem_valid) begin
                    loadIr    = 1'b1;
                    tmoClr    = 1'b1;
                    stateNext = S_ISSUE;
                end else if (tmoCnt == TMO_LAST) begin
                    setErr    = 1'b1;
                    tmoClr    = 1'b1;
                    stateNext = S_IDLE;
                end else begin
                    tmoInc = 1'b1;
                end
            end
            S_ISSUE: begin
                if (ex_done) begin
                    advancePc = 1'b1;
                    stateNext = S_REQ;
                end
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // PC, instruction register, timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcReg    <= RESET_PC;
            ir       <= '0;
            tmoCnt   <= '0;
            fetchErr <= 1'b0;
        end else begin
            if (loadIr) begin
                ir <= imem.imem_rdata;
            end
            if (advancePc) begin
                pcReg <= nextPc;
            end
            if (tmoClr) begin
                tmoCnt <= '0;
            end else if (tmoInc) begin
                tmoCnt <= tmoCnt + TMO_W'(1);
            end
            if (setErr) begin
                fetchErr <= 1'b1;
            end
        end
    end

    assign imem.imem_req  = (state == S_REQ);
    assign imem.imem_addr = pcReg;
    assign instr_valid    = (state == S_ISSUE);
    assign opcode         = instr_valid ? ir[15:13] : 3'b000;
    assign instr          = ir;
    assign pc             = pcReg;
    assign fetch_err      = fetchErr;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb/tb_instr_fetch_sequencer.sv - directed table-driven bench for instr_fetch_sequencer
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  opcode;
    logic [15:0] instr;
    logic        instr_valid;
    logic [15:0] pc;
    logic        j_in, beq_in, jmpg_in, alu_zero, alu_gt, ex_done;
    logic        fetch_err;

    int testsRun = 0;
    int testsFailed = 0;

    instr_fetch_sequencer_if #(.PC_W(16)) imemBus();

    instr_fetch_sequencer #(
        .PC_W     (16),
        .RESET_PC (16'h0000),
        .TIMEOUT  (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imemBus),
        .opcode      (opcode),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .j_in        (j_in),
        .beq_in      (beq_in),
        .jmpg_in     (jmpg_in),
        .alu_zero    (alu_zero),
        .alu_gt      (alu_gt),
        .ex_done     (ex_done),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          doReset;
        logic [15:0] rdata;
        bit          j;
        bit          beq;
        bit          jmpg;
        bit          zero;
        bit          gt;
        int          hold;
        logic [15:0] expPc;
        string       name;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    function automatic vec_t mk(bit rst, logic [15:0] rd, bit j, bit beq, bit jmpg,
                                bit zero, bit gt, int hold, logic [15:0] exp, string name);
        vec_t v;
        v.doReset = rst;
        v.rdata   = rd;
        v.j       = j;
        v.beq     = beq;
        v.jmpg    = jmpg;
        v.zero    = zero;
        v.gt      = gt;
        v.hold    = hold;
        v.expPc   = exp;
        v.name    = name;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        imemBus.imem_valid = 1'b0;
        imemBus.imem_rdata = 16'hDEAD;
        j_in     = 1'b0;
        beq_in   = 1'b0;
        jmpg_in  = 1'b0;
        alu_zero = 1'b0;
        alu_gt   = 1'b0;
        ex_done  = 1'b0;
    endtask

    task automatic applyReset();
        clearInputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic waitReq(string name);
        int n = 0;
        while (!imemBus.imem_req && n < 50) begin
            tick();
            n++;
        end
        check({name, "_req_wait"}, 32'(imemBus.imem_req), 32'd1);
    endtask

    task automatic runVec(vec_t v);
        if (v.doReset) begin
            applyReset();
        end
        waitReq(v.name);
        imemBus.imem_valid = 1'b1;
        imemBus.imem_rdata = v.rdata;
        tick();
        imemBus.imem_valid = 1'b0;
        imemBus.imem_rdata = 16'hDEAD;
        check({v.name, "_instr_valid"}, 32'(instr_valid), 32'd1);
        check({v.name, "_opcode"}, 32'(opcode), 32'(v.rdata[15:13]));
        check({v.name, "_instr"}, 32'(instr), 32'(v.rdata));
        for (int h = 0; h < v.hold; h++) begin
            j_in = 1'b1; beq_in = 1'b1; jmpg_in = 1'b1; alu_zero = 1'b1; alu_gt = 1'b1;
            tick();
        end
        if (v.hold > 0) begin
            check({v.name, "_hold_issue"}, 32'(instr_valid), 32'd1);
        end
        j_in = v.j; beq_in = v.beq; jmpg_in = v.jmpg; alu_zero = v.zero; alu_gt = v.gt;
        ex_done = 1'b1;
        tick();
        clearInputs();
        check({v.name, "_pc"}, 32'(pc), 32'(v.expPc));
        check({v.name, "_back_to_req"}, 32'(imemBus.imem_req), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        clearInputs();

        vecs[0]  = mk(1, 16'h0123, 0, 0, 0, 0, 0, 0, 16'h0001, "rtype");
        vecs[1]  = mk(0, 16'h8010, 1, 0, 0, 0, 0, 0, 16'h0010, "j_low");
        vecs[2]  = mk(0, 16'h607E, 0, 1, 0, 1, 0, 0, 16'h000F, "beq_taken_back");
        vecs[3]  = mk(0, 16'h8010, 1, 0, 0, 0, 0, 0, 16'h0010, "j_low2");
        vecs[4]  = mk(0, 16'h607E, 0, 1, 0, 0, 0, 0, 16'h0011, "beq_not_taken");
        vecs[5]  = mk(0, 16'h9FFF, 1, 0, 0, 0, 0, 0, 16'h1FFF, "j_region_top");
        vecs[6]  = mk(0, 16'h0000, 0, 0, 0, 0, 0, 2, 16'h2000, "seq_region_cross");
        vecs[7]  = mk(0, 16'h8005, 1, 0, 0, 0, 0, 0, 16'h2005, "j_region1");
        vecs[8]  = mk(0, 16'h8ABC, 1, 0, 0, 0, 0, 0, 16'h2ABC, "j_keep_region");
        vecs[9]  = mk(0, 16'h8005, 1, 0, 0, 0, 0, 0, 16'h2005, "j_back");
        vecs[10] = mk(0, 16'h8ABC, 1, 1, 1, 1, 1, 0, 16'h2ABC, "j_priority");
        vecs[11] = mk(0, 16'hE005, 0, 0, 1, 0, 1, 0, 16'h2AC2, "jmpg_taken");
        vecs[12] = mk(0, 16'hE005, 0, 0, 1, 0, 0, 0, 16'h2AC3, "jmpg_not_taken");
        vecs[13] = mk(0, 16'h6003, 0, 1, 1, 1, 0, 0, 16'h2AC7, "beq_under_jmpg");
        vecs[14] = mk(0, 16'hA07F, 0, 0, 0, 1, 1, 0, 16'h2AC8, "undef101");
        vecs[15] = mk(0, 16'hC07F, 0, 0, 0, 1, 1, 0, 16'h2AC9, "undef110");
        vecs[16] = mk(1, 16'h607E, 0, 1, 0, 1, 0, 0, 16'hFFFF, "wrap_back");
        vecs[17] = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h0000, "wrap_seq");
        vecs[18] = mk(0, 16'h607E, 0, 1, 0, 1, 0, 0, 16'hFFFF, "wrap_back2");
        vecs[19] = mk(0, 16'h6001, 0, 1, 0, 1, 0, 0, 16'h0001, "wrap_fwd_branch");
        vecs[20] = mk(0, 16'hE03F, 0, 0, 1, 0, 1, 0, 16'h0041, "max_offset");
        vecs[21] = mk(0, 16'h6040, 0, 1, 0, 1, 0, 0, 16'h0002, "min_offset");

        // Reset state and two-cycle-per-instruction timing.
        clearInputs();
        imemBus.imem_valid = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        imemBus.imem_valid = 1'b0;
        check("rst_imem_req", 32'(imemBus.imem_req), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_opcode", 32'(opcode), 32'd0);
        check("rst_pc", 32'(pc), 32'h0000);
        check("rst_instr", 32'(instr), 32'h0000);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        tick();
        check("c1_req", 32'(imemBus.imem_req), 32'd1);
        check("c1_addr", 32'(imemBus.imem_addr), 32'h0000);
        imemBus.imem_valid = 1'b1;
        imemBus.imem_rdata = 16'h0123;
        tick();
        imemBus.imem_valid = 1'b0;
        check("c2_issue", 32'(instr_valid), 32'd1);
        check("c2_req_low", 32'(imemBus.imem_req), 32'd0);
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        check("c3_req", 32'(imemBus.imem_req), 32'd1);
        check("c3_pc", 32'(pc), 32'h0001);

        // Directed vector table.
        for (int i = 0; i < NV; i++) begin
            runVec(vecs[i]);
        end

        // Fetch timeout: 15 REQ cycles without valid, then IDLE, then re-request.
        applyReset();
        tick();
        check("tmo_enter_req", 32'(imemBus.imem_req), 32'd1);
        for (int k = 0; k < 14; k++) begin
            ex_done = 1'b1;
            j_in = 1'b1;
            tick();
        end
        clearInputs();
        check("tmo_still_req", 32'(imemBus.imem_req), 32'd1);
        check("tmo_no_err_yet", 32'(fetch_err), 32'd0);
        tick();
        check("tmo_idle", 32'(imemBus.imem_req), 32'd0);
        check("tmo_err_set", 32'(fetch_err), 32'd1);
        check("tmo_not_issue", 32'(instr_valid), 32'd0);
        imemBus.imem_valid = 1'b1;
        imemBus.imem_rdata = 16'hFFFF;
        tick();
        imemBus.imem_valid = 1'b0;
        check("tmo_rereq", 32'(imemBus.imem_req), 32'd1);
        check("tmo_same_addr", 32'(imemBus.imem_addr), 32'h0000);
        check("tmo_idle_valid_ignored", 32'(instr), 32'h0000);
        tick();
        tick();
        check("tmo_wait2", 32'(imemBus.imem_req), 32'd1);
        imemBus.imem_valid = 1'b1;
        imemBus.imem_rdata = 16'h0123;
        tick();
        imemBus.imem_valid = 1'b0;
        check("tmo_late_issue", 32'(instr_valid), 32'd1);
        check("tmo_late_instr", 32'(instr), 32'h0123);
        ex_done = 1'b1;
        tick();
        ex_done = 1'b0;
        check("tmo_pc_adv", 32'(pc), 32'h0001);
        check("tmo_err_sticky", 32'(fetch_err), 32'd1);

        // Reset during ISSUE with ex_done and J asserted: no PC update.
        imemBus.imem_valid = 1'b1;
        imemBus.imem_rdata = 16'h8ABC;
        tick();
        imemBus.imem_valid = 1'b0;
        check("rsti_in_issue", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        ex_done = 1'b1;
        j_in = 1'b1;
        tick();
        rst_n = 1'b1;
        clearInputs();
        check("rsti_pc", 32'(pc), 32'h0000);
        check("rsti_instr_valid", 32'(instr_valid), 32'd0);
        check("rsti_instr", 32'(instr), 32'h0000);
        check("rsti_err_clr", 32'(fetch_err), 32'd0);
        check("rsti_req", 32'(imemBus.imem_req), 32'd0);

        // Reset during REQ with imem_valid in the same cycle: instruction discarded.
        tick();
        check("rstr_in_req", 32'(imemBus.imem_req), 32'd1);
        rst_n = 1'b0;
        imemBus.imem_valid = 1'b1;
        imemBus.imem_rdata = 16'h8ABC;
        tick();
        rst_n = 1'b1;
        clearInputs();
        check("rstr_instr", 32'(instr), 32'h0000);
        check("rstr_instr_valid", 32'(instr_valid), 32'd0);
        check("rstr_req", 32'(imemBus.imem_req), 32'd0);
        check("rstr_pc", 32'(pc), 32'h0000);
        tick();
        tick();
        check("rstr_rereq", 32'(imemBus.imem_req), 32'd1);
        check("rstr_no_issue", 32'(instr_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
